tetris_grid_renderer: RTL

//   Parametrised, pipelined successor to the monochrome grid drawer. Renders a COLS x ROWS

---
 rtl/tetris_gfx_pkg.sv | 36 +++
 rtl/grid_axis_tracker.sv | 59 +++++
 rtl/tetris_grid_renderer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tetris_gfx_pkg.sv
// Shared graphics definitions for the colour grid renderer: colours, palette, default pitch.
package tetris_gfx_pkg;

  localparam logic [11:0] C_FRAME = 12'hFFF;
  localparam logic [11:0] C_BG    = 12'h000;

  localparam int DEF_BLOCK_SIZE = 17;
  localparam int DEF_GAP        = 4;
  localparam int PITCH          = DEF_BLOCK_SIZE + DEF_GAP;

  // Palette lookup; index 0 means empty and never reaches the screen.
  // Entries 8..15 extend the base 3-bit palette for boards with 4-bit cells.
  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] rgb;
    case (idx)
      4'd1:    rgb = 12'h0FF;
      4'd2:    rgb = 12'hFF0;
      4'd3:    rgb = 12'hA0F;
      4'd4:    rgb = 12'h0F0;
      4'd5:    rgb = 12'hF00;
      4'd6:    rgb = 12'h00F;
      4'd7:    rgb = 12'hF80;
      4'd8:    rgb = 12'h888;
      4'd9:    rgb = 12'hF0F;
      4'd10:   rgb = 12'h08F;
      4'd11:   rgb = 12'h8F0;
      4'd12:   rgb = 12'hF88;
      4'd13:   rgb = 12'h8FF;
      4'd14:   rgb = 12'h48C;
      4'd15:   rgb = 12'hCCC;
      default: rgb = C_BG;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/grid_axis_tracker.sv
// Follows one VGA counter across the board: which block we are in and whether the
// current pixel lies inside that block or in the gap after it.
module grid_axis_tracker #(
  parameter int START      = 340,
  parameter int COUNT      = 12,
  parameter int BLOCK_SIZE = 17,
  parameter int GAP        = 4,
  parameter int IDX_W      = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       i_count,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_in_block,
  output logic             o_active
);

  localparam int          PITCH_L = BLOCK_SIZE + GAP;
  localparam int          OFF_W   = $clog2(PITCH_L);
  localparam logic [9:0]  START_V = 10'(START);

  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_off;
  logic             r_active;
  logic [9:0]       r_prev;

  // Restart at the first block pixel, step the offset whenever the counter moves,
  // roll into the next block after the gap and go idle past the last block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_off    <= '0;
      r_active <= 1'b0;
      r_prev   <= '0;
    end else begin
      r_prev <= i_count;
      if (i_count == START_V) begin
        r_idx    <= '0;
        r_off    <= '0;
        r_active <= 1'b1;
      end else if (i_count < START_V) begin
        r_active <= 1'b0;
      end else if (r_active && (i_count != r_prev)) begin
        if (r_off == OFF_W'(PITCH_L - 1)) begin
          r_off <= '0;
          if (r_idx == IDX_W'(COUNT - 1)) r_active <= 1'b0;
          else                            r_idx    <= r_idx + 1'b1;
        end else begin
          r_off <= r_off + 1'b1;
        end
      end
    end
  end

  assign o_idx      = r_idx;
  assign o_active   = r_active;
  assign o_in_block = r_active && (r_off < OFF_W'(BLOCK_SIZE));

endmodule

// File: rtl/tetris_grid_renderer.sv
// Two-stage colour renderer for the board: S1 registers the counters and tracks both
// axes, S2 looks up the cell, resolves frame/block/background and registers RGB.
module tetris_grid_renderer
  import tetris_gfx_pkg::*;
#(
  parameter int COLS         = 12,
  parameter int ROWS         = 20,
  parameter int CELL_BITS    = 3,
  parameter int BLOCK_SIZE   = 17,
  parameter int GAP          = 4,
  parameter int COL_START    = 340,
  parameter int ROW_START    = 67,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    counter_x,
  input  logic [9:0]                    counter_y,
  input  logic                          frame_start,
  input  logic [COLS*ROWS*CELL_BITS-1:0] grid,
  input  logic [ROWS-1:0]               flash_rows,
  output logic [3:0]                    r_red,
  output logic [3:0]                    r_green,
  output logic [3:0]                    r_blue
);

  localparam int GRID_W  = COLS * ROWS * CELL_BITS;
  localparam int GB_W    = $clog2(GRID_W);
  localparam int PITCH_L = BLOCK_SIZE + GAP;
  localparam int COL_END = COL_START + COLS * PITCH_L - GAP - 1;
  localparam int ROW_END = ROW_START + ROWS * PITCH_L - GAP - 1;
  localparam int XI_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YI_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] FRAME_L = 10'(COL_START - GAP);
  localparam logic [9:0] FRAME_R = 10'(COL_END + GAP);
  localparam logic [9:0] FRAME_T = 10'(ROW_START - GAP);
  localparam logic [9:0] FRAME_B = 10'(ROW_END + GAP);

  logic [GRID_W-1:0] r_grid_snap;
  logic [ROWS-1:0]   r_flash_snap;
  logic [FC_W-1:0]   r_frame_cnt;
  logic              r_blink_phase;
  logic [9:0]        r_x;
  logic [9:0]        r_y;

  logic [XI_W-1:0]      w_col;
  logic [YI_W-1:0]      w_row;
  logic                 w_x_in;
  logic                 w_y_in;
  logic                 w_x_act;
  logic                 w_y_act;
  logic [GB_W-1:0]      w_base;
  logic [CELL_BITS-1:0] w_cell;
  logic                 w_on_frame;
  logic [11:0]          w_rgb;

  grid_axis_tracker #(
    .START(COL_START), .COUNT(COLS), .BLOCK_SIZE(BLOCK_SIZE), .GAP(GAP), .IDX_W(XI_W)
  ) u_x_tracker (
    .clk(clk), .rst(rst), .i_count(counter_x),
    .o_idx(w_col), .o_in_block(w_x_in), .o_active(w_x_act)
  );

  grid_axis_tracker #(
    .START(ROW_START), .COUNT(ROWS), .BLOCK_SIZE(BLOCK_SIZE), .GAP(GAP), .IDX_W(YI_W)
  ) u_y_tracker (
    .clk(clk), .rst(rst), .i_count(counter_y),
    .o_idx(w_row), .o_in_block(w_y_in), .o_active(w_y_act)
  );

  // Latch the board once per frame and advance the flash blink on each frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grid_snap   <= '0;
      r_flash_snap  <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_start) begin
      r_grid_snap  <= grid;
      r_flash_snap <= flash_rows;
      if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // S1: delay the counters so they line up with the tracker state in S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= counter_x;
      r_y <= counter_y;
    end
  end

  assign w_base = GB_W'(((ROWS - 1 - int'(w_row)) * COLS + int'(w_col)) * CELL_BITS);
  assign w_cell = r_grid_snap[w_base +: CELL_BITS];

  assign w_on_frame =
    (((r_x == FRAME_L) || (r_x == FRAME_R)) && (r_y >= FRAME_T) && (r_y <= FRAME_B)) ||
    (((r_y == FRAME_T) || (r_y == FRAME_B)) && (r_x >= FRAME_L) && (r_x <= FRAME_R));

  // S2 colour choice: frame wins, then a filled block (white while its row flashes).
  always_comb begin
    w_rgb = C_BG;
    if (w_on_frame) begin
      w_rgb = C_FRAME;
    end else if (w_x_act && w_y_act && w_x_in && w_y_in && (w_cell != '0)) begin
      if (r_flash_snap[w_row] && r_blink_phase) w_rgb = C_FRAME;
      else                                      w_rgb = palette(4'(w_cell));
    end
  end

  // S2 output register; reset blanks the screen from the very next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_red   <= w_rgb[11:8];
      r_green <= w_rgb[7:4];
      r_blue  <= w_rgb[3:0];
    end
  end

endmodule
